// File: rtl/uart_tx_arb.sv
// uart_tx_arb: packet-level round-robin arbiter sharing one uart_tx byte transmitter among N requesters.
// Ports: clk, rst_n (async active-low); in_data_i/in_valid_i/in_last_i/in_ready_o are the N requester
// byte lanes (lane i = in_data_i[8i+7:8i]); out_data_o/out_valid_o/out_ready_i connect to uart_tx;
// grant_id_o is the current or most recent grant, busy_o is high while a packet owns the line, and
// wd_release_o pulses for one cycle when a packet is cut at MAX_PKT bytes.
// Optional macro UART_TX_ARB_ID_HDR_EN: prefix every grant with the header byte {4'hA, grant_id}.
module uart_tx_arb #(
   parameter int N       = 4,
   parameter int MAX_PKT = 64
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N*8-1:0]          in_data_i,
   input  logic [N-1:0]            in_valid_i,
   input  logic [N-1:0]            in_last_i,
   output logic [N-1:0]            in_ready_o,
   output logic [7:0]              out_data_o,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic [((N>1)?$clog2(N):1)-1:0] grant_id_o,
   output logic                    busy_o,
   output logic                    wd_release_o
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, GRANT, HDR} state_e;

   state_e        state_q, state_d;
   logic [IW-1:0] grant_q, grant_d, last_q, last_d, sel;
   logic [7:0]    beat_q, beat_d;
   logic          wd_q, wd_d;

   // Walk the ring downwards from last_q+N to last_q+1 so the final hit is the closest requester after last_q.
   always_comb begin
      logic [IW-1:0] idx;
      sel = '0;
      for (int k = N; k >= 1; k--) begin
         idx = IW'((int'(last_q) + k) % N);
         if (in_valid_i[idx]) sel = idx;
      end
   end

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      last_d      = last_q;
      beat_d      = beat_q;
      wd_d        = 1'b0;
      out_valid_o = 1'b0;
      out_data_o  = '0;
      in_ready_o  = '0;
      case (state_q)
         IDLE: if (|in_valid_i) begin
            grant_d = sel;
            last_d  = sel;
            beat_d  = '0;
`ifdef UART_TX_ARB_ID_HDR_EN
            state_d = HDR;
`else
            state_d = GRANT;
`endif
         end
`ifdef UART_TX_ARB_ID_HDR_EN
         HDR: begin
            out_valid_o = 1'b1;
            out_data_o  = {4'hA, 4'(grant_q)};
            if (out_ready_i) state_d = GRANT;
         end
`endif
         GRANT: begin
            out_data_o          = in_data_i[{grant_q, 3'b000} +: 8];
            out_valid_o         = in_valid_i[grant_q];
            in_ready_o[grant_q] = out_ready_i;
            if (in_valid_i[grant_q] && out_ready_i) begin
               beat_d = beat_q + 8'd1;
               if (in_last_i[grant_q]) state_d = IDLE;
               else if (beat_q + 8'd1 == 8'(MAX_PKT)) begin
                  state_d = IDLE;
                  wd_d    = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= IW'(N - 1);
         beat_q  <= '0;
         wd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         beat_q  <= beat_d;
         wd_q    <= wd_d;
      end
   end

   assign grant_id_o   = grant_q;
   assign busy_o       = state_q != IDLE;
   assign wd_release_o = wd_q;
endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: scoreboard bench for uart_tx_arb with directed packets and randomized traffic.
module tb_uart_tx_arb;
   localparam int N  = 4;
   localparam int MP = 4;
`ifdef UART_TX_ARB_ID_HDR_EN
   localparam bit HDR_EN = 1'b1;
`else
   localparam bit HDR_EN = 1'b0;
`endif

   logic           clk = 1'b0, rst_n = 1'b0;
   logic [N*8-1:0] in_data;
   logic [N-1:0]   in_valid, in_last, in_ready;
   logic [7:0]     out_data;
   logic           out_valid, out_ready;
   logic [1:0]     grant_id;
   logic           busy, wd_release;

   always #5 clk = ~clk;

   uart_tx_arb #(.N(N), .MAX_PKT(MP)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_data_i(in_data), .in_valid_i(in_valid), .in_last_i(in_last), .in_ready_o(in_ready),
      .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
      .grant_id_o(grant_id), .busy_o(busy), .wd_release_o(wd_release)
   );

   int         n_cmp = 0, n_bad = 0;
   logic [8:0] sq[N][$];
   logic [8:0] exp_q[N][$];
   logic [N-1:0] pres = '0;
   int         gorder[$];
   int         n_bytes = 0, n_wd = 0;
   bit         rnd = 1'b0;

   int         m_last = N - 1, cur_g = 0, beats = 0;
   logic       prev_busy = 1'b0;
   logic [N-1:0] prev_valid = '0;
   bit         hdr_pend = 1'b0, chk_end = 1'b0, wd_exp = 1'b0;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
      end
   endtask

   function automatic bit all_empty();
      for (int i = 0; i < N; i++) if (exp_q[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic add_byte(int r, logic [7:0] d, bit last);
      sq[r].push_back({last, d});
      exp_q[r].push_back({last, d});
   endtask

   // Monitor: the expected winner is simply the nearest requesting index after the previous winner.
   always @(negedge clk) begin
      int w;
      logic [8:0] e;
      logic [N-1:0] er;
      if (!rst_n) begin
         chk("rst_busy", busy, 0);
         chk("rst_out_valid", out_valid, 0);
         chk("rst_in_ready", in_ready, 0);
         chk("rst_grant_id", grant_id, 0);
         chk("rst_wd", wd_release, 0);
         m_last = N - 1; prev_busy = 0; prev_valid = '0; hdr_pend = 0; chk_end = 0; wd_exp = 0;
      end else begin
         if (chk_end || wd_release) chk("wd_release", wd_release, wd_exp);
         if (chk_end) chk("busy_drop", busy, 0);
         chk_end = 0; wd_exp = 0;
         if (busy && !prev_busy) begin
            w = -1;
            for (int k = 1; k <= N; k++) if (w < 0 && prev_valid[(m_last + k) % N]) w = (m_last + k) % N;
            chk("grant", grant_id, w);
            cur_g = (w < 0) ? int'(grant_id) : w;
            m_last = cur_g; beats = 0; hdr_pend = HDR_EN;
            gorder.push_back(cur_g);
         end else if (busy) chk("grant_hold", grant_id, cur_g);
         if (!busy) begin
            chk("idle_out_valid", out_valid, 0);
            chk("idle_in_ready", in_ready, 0);
         end else if (hdr_pend) begin
            chk("hdr_valid", out_valid, 1);
            chk("hdr_in_ready", in_ready, 0);
            if (out_ready) begin
               chk("hdr_data", out_data, {4'hA, 4'(cur_g)});
               hdr_pend = 0;
            end
         end else begin
            er = '0; er[cur_g] = out_ready;
            chk("pass_valid", out_valid, in_valid[cur_g]);
            chk("pass_in_ready", in_ready, er);
            if (out_valid && out_ready) begin
               n_bytes++; beats++;
               if (exp_q[cur_g].size() == 0) chk("unexpected_byte", out_data, 32'hdead);
               else begin
                  e = exp_q[cur_g].pop_front();
                  chk("data", out_data, e[7:0]);
                  if (e[8]) chk_end = 1;
                  else if (beats == MP) begin chk_end = 1; wd_exp = 1; n_wd++; end
               end
            end
         end
         prev_busy = busy; prev_valid = in_valid;
      end
   end

   // Per-lane requester: holds a byte until it is accepted, optionally inserting random valid gaps.
   task automatic drive(int maxc, int stop);
      int c = 0;
      logic [N-1:0] acc;
      while (c < maxc && !all_empty() && n_bytes < stop) begin
         @(negedge clk);
         acc = in_valid & in_ready;
         @(posedge clk); #1;
         c++;
         for (int i = 0; i < N; i++) begin
            if (acc[i]) begin pres[i] = 1'b0; void'(sq[i].pop_front()); end
            if (!pres[i] && sq[i].size() > 0 && (!rnd || $urandom_range(3) != 0)) pres[i] = 1'b1;
            in_valid[i]       = pres[i];
            in_data[8*i +: 8] = pres[i] ? sq[i][0][7:0] : 8'($urandom);
            in_last[i]        = pres[i] ? sq[i][0][8] : 1'($urandom);
         end
         out_ready = rnd ? ($urandom_range(3) != 0) : 1'b1;
      end
      chk("drive_timeout", c < maxc, 1);
   endtask

   task automatic settle();
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_grant_id", grant_id, 0);
      #1;
      // Single 3-byte packet from requester 2
      add_byte(2, 8'h11, 0); add_byte(2, 8'h22, 0); add_byte(2, 8'h33, 1);
      drive(200, 1 << 30); settle();
      chk("grant_id_after_req2", grant_id, 2);
      // Req 0 posts two packets back to back, req 1 one packet: req 1 must slot in between
      gorder.delete();
      add_byte(0, 8'hA0, 0); add_byte(0, 8'hA1, 1); add_byte(0, 8'hC0, 0); add_byte(0, 8'hC1, 1);
      add_byte(1, 8'hB0, 0); add_byte(1, 8'hB1, 1);
      drive(200, 1 << 30); settle();
      chk("rr_count", gorder.size(), 3);
      if (gorder.size() == 3) begin
         chk("rr_first", gorder[0], 0); chk("rr_second", gorder[1], 1); chk("rr_third", gorder[2], 0);
      end
      // Watchdog: 6-byte packet with MAX_PKT=4 splits into two grants
      gorder.delete(); n_wd = 0;
      for (int b = 0; b < 6; b++) add_byte(3, 8'(8'h60 + b), b == 5);
      drive(200, 1 << 30); settle();
      chk("wd_pulses", n_wd, 1);
      chk("wd_grants", gorder.size(), 2);
      // Reset after the first byte of a packet
      add_byte(2, 8'h71, 0); add_byte(2, 8'h72, 0); add_byte(2, 8'h73, 1);
      drive(200, n_bytes + 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_in_ready", in_ready, 0);
      chk("mid_rst_grant_id", grant_id, 0);
      for (int i = 0; i < N; i++) begin sq[i].delete(); exp_q[i].delete(); end
      pres = '0; in_valid = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      gorder.delete();
      add_byte(3, 8'h77, 1); add_byte(1, 8'h5A, 1);
      drive(200, 1 << 30); settle();
      chk("post_rst_first", (gorder.size() > 0) ? gorder[0] : -1, 1);
      if (HDR_EN) begin
         add_byte(1, 8'hC3, 1);
         drive(200, 1 << 30); settle();
      end
      // Randomized traffic with valid gaps, ready stalls and packets longer than MAX_PKT
      rnd = 1'b1;
      for (int p = 0; p < 150; p++) begin
         int r, len;
         r = $urandom_range(N - 1);
         len = $urandom_range(7, 1);
         for (int b = 0; b < len; b++) add_byte(r, 8'($urandom), b == len - 1);
      end
      drive(20000, 1 << 30);
      rnd = 1'b0;
      settle();
      chk("final_idle", busy, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Packet-level round-robin arbiter that shares one uart_tx byte transmitter among N requesters.
- Each requester presents a byte stream with a last flag.
- The grant is locked for a whole packet, so bytes from different sources never interleave on the serial line.
- Sits directly upstream of uart_tx: out_* connects to uart_tx in_data/in_valid/in_ready.

Parameters:
- N, 4, number of requesters; legal range 1..16.
- MAX_PKT, 64, watchdog limit: maximum bytes per grant before forced release; legal range 1..255.
- IW, $clog2(N) (1 when N=1), width of the requester index; derived localparam, not overridable.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_data  in  N*8  requester byte lanes; lane i = bits [8i+7:8i]
- in_valid  in  N  per-requester byte valid
- in_last  in  N  per-requester last-byte-of-packet flag, qualified by in_valid
- in_ready  out  N  per-requester byte accepted
- out_data  out  8  byte to uart_tx
- out_valid  out  1  byte valid to uart_tx
- out_ready  in  1  uart_tx ready
- grant_id  out  IW  index of the current or most recent grant
- busy  out  1  high while in GRANT (or HDR) state
- wd_release  out  1  one-cycle pulse when the watchdog forces release

Behaviour:
- Reset (async assert, sync deassert by the upstream reset bridge):
  - state=IDLE, last_grant=N-1 (requester 0 has first priority), beat_cnt=0.
  - grant_id=0, busy=0, wd_release=0, out_valid=0, in_ready=0.
- Handshake: a byte transfers on a clk rising edge with valid&ready high. Requesters must hold data/last stable while valid is high and not ready.
- IDLE:
  - out_valid=0, all in_ready=0.
  - If any in_valid is set, select the first set bit searching circularly from last_grant+1.
  - Next cycle: register grant_id and last_grant, go to GRANT, clear beat_cnt.
  - Arbitration latency is exactly 1 cycle. Requests sampled in IDLE only.
- GRANT (g = grant_id):
  - out_data = lane g; out_valid = in_valid[g]; in_ready[g] = out_ready; all other in_ready=0.
  - Combinational pass-through, zero added latency, no buffering.
  - Each accepted byte increments beat_cnt (8-bit).
  - Accepted byte with in_last[g]=1: go to IDLE next cycle.
  - Accepted byte reaching beat_cnt==MAX_PKT without last: pulse wd_release, go to IDLE. The requester's remaining bytes form a new packet and arbitrate again.
  - Last and watchdog on the same byte: normal release; wd_release stays 0.
  - Granted requester dropping valid mid-packet: grant held indefinitely (the watchdog counts only accepted bytes).
- Back-to-back packets: one idle bubble cycle between packets. A requester requesting continuously loses priority to any other pending requester.
- N=1: always grants 0; behaviour otherwise identical.
- Reset mid-packet: immediate return to reset values. A partially sent packet is abandoned; uart_tx is reset by the same rst_n.
- in_valid/in_last bits for non-granted requesters have no effect during GRANT.

Optional Feature:
- Macro: UART_TX_ARB_ID_HDR_EN.
- Defined:
  - An extra state HDR sits between IDLE and GRANT.
  - In HDR: out_valid=1, out_data={4'hA, grant_id zero-extended to 4 bits}, all in_ready=0.
  - Move to GRANT once out_ready is high.
  - The header does not count toward beat_cnt; busy=1 in HDR.
- Undefined: no HDR state; IDLE goes directly to GRANT; no header bytes on the line.

Test Plan:
- Reset then idle, all in_valid=0 for 10 cycles -> out_valid=0, busy=0, in_ready=0, grant_id=0.
- Req 2 sends 3-byte packet 8'h11,8'h22,8'h33 (last on 8'h33) -> uart_rx receives 11,22,33 in order; busy drops the cycle after the 8'h33 handshake; grant_id=2.
- Reqs 0 and 1 both post 2-byte packets in the same cycle while req 0 holds valid continuously -> order req0, req1, req0; no byte interleaving.
- Watchdog with MAX_PKT=4, req 3 streams 6 bytes with last on byte 6 -> wd_release pulses once after byte 4; bytes 5-6 sent in a second grant; all 6 bytes received in order.
- rst_n asserted after byte 1 of a 3-byte packet -> outputs return to reset values immediately; after release, req 1 packet 8'h5A (last) arbitrates first and is received intact.
- With UART_TX_ARB_ID_HDR_EN, req 1 sends 8'hC3 (last) -> uart_rx receives 8'hA1 then 8'hC3.
